// File: rtl/step_scheduler_if.sv
// Step scheduler control/status bundle.
//   master : sequencer controller (drives run/hold/rate, observes step status)
//   slave  : step_scheduler itself
// Signals:
//   run        level, 1 = running, 0 = stopped and rewound
//   hold       level, 1 = freeze position while running
//   rate_in    new rate; step period = rate_in + 1 clk cycles
//   rate_load  one-cycle strobe capturing rate_in
//   rate_busy  captured rate pending, not yet applied
//   step_idx   current step index
//   step_pulse one-cycle strobe at start of each step
//   bar_pulse  one-cycle strobe with step_pulse when step_idx becomes 0
//   active     high while running or held
interface step_scheduler_if #(
   parameter int unsigned STEPS  = 8,
   parameter int unsigned RATE_W = 28
);
   localparam int unsigned IdxW = $clog2(STEPS);

   logic              run;
   logic              hold;
   logic [RATE_W-1:0] rate_in;
   logic              rate_load;
   logic              rate_busy;
   logic [IdxW-1:0]   step_idx;
   logic              step_pulse;
   logic              bar_pulse;
   logic              active;

   modport master (
      output run, hold, rate_in, rate_load,
      input  rate_busy, step_idx, step_pulse, bar_pulse, active
   );

   modport slave (
      input  run, hold, rate_in, rate_load,
      output rate_busy, step_idx, step_pulse, bar_pulse, active
   );
endinterface

// File: rtl/step_scheduler.sv
// Step scheduler: divides clk into steps of (rate + 1) cycles and walks a
// step index 0..STEPS-1, flagging each step start and each bar start.
// Rate changes made while running are deferred to the next step boundary.
// Ports:
//   clk_i     single clock, rising edge
//   reset_ni  asynchronous active-low reset
//   bus       step_scheduler_if.slave (control in, registered status out)
module step_scheduler #(
   parameter int unsigned       STEPS        = 8,
   parameter int unsigned       RATE_W       = 28,
   parameter logic [RATE_W-1:0] DEFAULT_RATE = RATE_W'(12_499_999)
) (
   input logic               clk_i,
   input logic               reset_ni,
   step_scheduler_if.slave   bus
);
   localparam int unsigned IdxW = $clog2(STEPS);

   typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

   state_e            state_q, state_d;
   logic [RATE_W-1:0] cnt_q, cnt_d;
   logic [RATE_W-1:0] rate_q, rate_d;
   logic [RATE_W-1:0] pend_q, pend_d;
   logic              busy_q, busy_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic              step_q, step_d;
   logic              bar_q, bar_d;
   logic              active_q, active_d;

   logic [RATE_W-1:0] next_rate;
   logic [IdxW-1:0]   idx_inc;

   // Rate taken at a reload/start/stop: a same-cycle load wins over a pending
   // one, which wins over the current active rate.
   always_comb begin
      next_rate = rate_q;
      if (bus.rate_load) begin
         next_rate = bus.rate_in;
      end else if (busy_q) begin
         next_rate = pend_q;
      end
   end

   // STEPS is a power of two, so the natural IdxW-bit overflow is the wrap.
   assign idx_inc = idx_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rate_d  = rate_q;
      pend_d  = pend_q;
      busy_d  = busy_q;
      idx_d   = idx_q;
      step_d  = 1'b0;
      bar_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.rate_load) begin
               rate_d = bus.rate_in;
            end
            if (bus.run) begin
               state_d = StRun;
               cnt_d   = next_rate;
               rate_d  = next_rate;
               busy_d  = 1'b0;
               idx_d   = '0;
               step_d  = 1'b1;
               bar_d   = 1'b1;
            end
         end
         StRun, StHold: begin
            if (!bus.run) begin
               // Stop wins over hold and expiry; flush any pending rate.
               state_d = StIdle;
               cnt_d   = '0;
               idx_d   = '0;
               rate_d  = next_rate;
               busy_d  = 1'b0;
            end else if (bus.hold) begin
               state_d = StHold;
               if (bus.rate_load) begin
                  pend_d = bus.rate_in;
                  busy_d = 1'b1;
               end
            end else begin
               // Leaving HOLD counts this cycle, same as a RUN cycle.
               state_d = StRun;
               if (cnt_q == '0) begin
                  cnt_d  = next_rate;
                  rate_d = next_rate;
                  busy_d = 1'b0;
                  idx_d  = idx_inc;
                  step_d = 1'b1;
                  bar_d  = (idx_inc == '0);
               end else begin
                  cnt_d = cnt_q - 1'b1;
                  if (bus.rate_load) begin
                     pend_d = bus.rate_in;
                     busy_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      active_d = (state_d != StIdle);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         rate_q   <= DEFAULT_RATE;
         pend_q   <= '0;
         busy_q   <= 1'b0;
         idx_q    <= '0;
         step_q   <= 1'b0;
         bar_q    <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rate_q   <= rate_d;
         pend_q   <= pend_d;
         busy_q   <= busy_d;
         idx_q    <= idx_d;
         step_q   <= step_d;
         bar_q    <= bar_d;
         active_q <= active_d;
      end
   end

   assign bus.rate_busy  = busy_q;
   assign bus.step_idx   = idx_q;
   assign bus.step_pulse = step_q;
   assign bus.bar_pulse  = bar_q;
   assign bus.active     = active_q;
endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler (STEPS=8, RATE_W=28, DEFAULT_RATE=3).
module tb_step_scheduler;
   logic clk_i;
   logic reset_ni;
   int   checks;
   int   failures;

   step_scheduler_if #(.STEPS(8), .RATE_W(28)) sif ();

   step_scheduler #(
      .STEPS       (8),
      .RATE_W      (28),
      .DEFAULT_RATE(28'd3)
   ) dut (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .bus     (sif)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic p, input logic b, input int idx,
                          input logic act);
      chk({tag, "_pulse"}, 32'(sif.step_pulse), 32'(p));
      chk({tag, "_bar"}, 32'(sif.bar_pulse), 32'(b));
      chk({tag, "_idx"}, 32'(sif.step_idx), 32'(idx));
      chk({tag, "_active"}, 32'(sif.active), 32'(act));
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      reset_ni      = 1'b1;
      sif.run       = 1'b0;
      sif.hold      = 1'b0;
      sif.rate_in   = '0;
      sif.rate_load = 1'b0;

      // Reset state, applied between clock edges.
      #2 reset_ni = 1'b0;
      #1;
      chk_out("rst", 1'b0, 1'b0, 0, 1'b0);
      chk("rst_busy", 32'(sif.rate_busy), 0);
      step();
      step();
      reset_ni = 1'b1;
      step();
      chk_out("idle", 1'b0, 1'b0, 0, 1'b0);

      // Default rate 3: pulses at cycles 1,5,9,...; bars at 1 and 33.
      sif.run = 1'b1;
      for (int c = 1; c <= 33; c++) begin
         step();
         chk_out($sformatf("run_c%0d", c), ((c - 1) % 4) == 0,
                 ((c - 1) % 32) == 0, ((c - 1) / 4) % 8, 1'b1);
      end

      // Hold for 10 cycles mid-step: step period becomes 14.
      step();                             // c34, counter=2
      chk_out("pre_hold", 1'b0, 1'b0, 0, 1'b1);
      sif.hold = 1'b1;
      for (int k = 0; k < 10; k++) begin  // c35..c44 frozen
         step();
         chk_out($sformatf("hold_k%0d", k), 1'b0, 1'b0, 0, 1'b1);
      end
      sif.hold = 1'b0;
      step();                             // c45
      chk_out("resume_a", 1'b0, 1'b0, 0, 1'b1);
      step();                             // c46
      chk_out("resume_b", 1'b0, 1'b0, 0, 1'b1);
      step();                             // c47, 14 cycles after c33
      chk_out("resume_pulse", 1'b1, 1'b0, 1, 1'b1);

      // Rate change to 1 while running, loaded at counter=2.
      step();                             // c48, counter=2
      sif.rate_in   = 28'd1;
      sif.rate_load = 1'b1;
      step();                             // c49
      sif.rate_load = 1'b0;
      chk("pend_busy_a", 32'(sif.rate_busy), 1);
      chk("pend_pulse_a", 32'(sif.step_pulse), 0);
      step();                             // c50
      chk("pend_busy_b", 32'(sif.rate_busy), 1);
      chk("pend_pulse_b", 32'(sif.step_pulse), 0);
      step();                             // c51 reload with rate 1
      chk_out("apply", 1'b1, 1'b0, 2, 1'b1);
      chk("apply_busy", 32'(sif.rate_busy), 0);
      step();
      chk("fast_gap_a", 32'(sif.step_pulse), 0);
      step();
      chk_out("fast_p3", 1'b1, 1'b0, 3, 1'b1);
      step();
      chk("fast_gap_b", 32'(sif.step_pulse), 0);
      step();                             // c55
      chk_out("fast_p4", 1'b1, 1'b0, 4, 1'b1);
      chk("fast_busy", 32'(sif.rate_busy), 0);

      // run dropped with hold=1 on the counter-expiry cycle.
      step();                             // c56, counter=0
      sif.run  = 1'b0;
      sif.hold = 1'b1;
      step();
      chk_out("stop", 1'b0, 1'b0, 0, 1'b0);
      sif.hold = 1'b0;

      // Async reset mid-run with a pending rate; restart uses DEFAULT_RATE.
      sif.run = 1'b1;
      step();
      chk_out("r2_start", 1'b1, 1'b1, 0, 1'b1);
      sif.rate_in   = 28'd5;
      sif.rate_load = 1'b1;
      step();
      sif.rate_load = 1'b0;
      chk("r2_busy", 32'(sif.rate_busy), 1);
      #3 reset_ni = 1'b0;
      #1;
      chk_out("r2_async", 1'b0, 1'b0, 0, 1'b0);
      chk("r2_async_busy", 32'(sif.rate_busy), 0);
      sif.run = 1'b0;
      step();
      step();
      reset_ni = 1'b1;
      step();
      sif.run = 1'b1;
      step();
      chk_out("r3_c1", 1'b1, 1'b1, 0, 1'b1);
      for (int c = 2; c <= 4; c++) begin
         step();
         chk_out($sformatf("r3_c%0d", c), 1'b0, 1'b0, 0, 1'b1);
      end
      step();
      chk_out("r3_c5", 1'b1, 1'b0, 1, 1'b1);
      chk("r3_busy", 32'(sif.rate_busy), 0);

      // rate 0 loaded in IDLE: pulse every cycle, bar every 8.
      sif.run = 1'b0;
      step();
      sif.rate_in   = 28'd0;
      sif.rate_load = 1'b1;
      step();
      sif.rate_load = 1'b0;
      chk("idle_load_busy", 32'(sif.rate_busy), 0);
      chk("idle_load_active", 32'(sif.active), 0);
      sif.run = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         step();
         chk_out($sformatf("r0_c%0d", c), 1'b1, ((c - 1) % 8) == 0, (c - 1) % 8, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
